// File: rtl/riscv_pkg.sv
// Shared pipeline types: decoded control bundle, ALU opcodes and default widths.
package riscv_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [3:0] alu_op;
    } ctrl_t;

    // All-zero control: no register or memory write, safe as a bubble.
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              lu
);

    logic src_match;

    assign src_match = (id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd));

    // x0 is hardwired, so a load targeting it can never create a dependence.
    assign lu = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid && src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and memory freeze.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_r_data1,
    input  logic [XLEN-1:0]   id_r_data2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  ctrl_t             id_ctrl,
    input  logic              flush,
    input  logic              freeze,
    output logic              stall_if,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [XLEN-1:0]   ex_r_data1,
    output logic [XLEN-1:0]   ex_r_data2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc,
    output ctrl_t             ex_ctrl
);

    logic lu;

    load_use_detect #(.REG_AW(REG_AW)) u_lu (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .lu          (lu)
    );

    // A flushed instruction is being discarded, so there is nothing to hold upstream.
    assign stall_if = freeze || (lu && !flush);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_r_data1 <= '0;
            ex_r_data2 <= '0;
            ex_imm     <= '0;
            ex_pc      <= '0;
            ex_ctrl    <= CTRL_NOP;
        end else if (freeze) begin
            // Hold everything; an accompanying flush is re-presented once unfrozen.
        end else if (flush || lu) begin
            ex_valid   <= 1'b0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_r_data1 <= '0;
            ex_r_data2 <= '0;
            ex_imm     <= '0;
            ex_pc      <= '0;
            ex_ctrl    <= CTRL_NOP;
        end else begin
            ex_valid   <= id_valid;
            ex_rs1     <= id_rs1;
            ex_rs2     <= id_rs2;
            ex_rd      <= id_rd;
            ex_r_data1 <= id_r_data1;
            ex_r_data2 <= id_r_data2;
            ex_imm     <= id_imm;
            ex_pc      <= id_pc;
            ex_ctrl    <= id_valid ? id_ctrl : CTRL_NOP;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              id_valid = 1'b0;
    logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic              id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic [XLEN-1:0]   id_r_data1 = '0, id_r_data2 = '0, id_imm = '0, id_pc = '0;
    ctrl_t             id_ctrl = '0;
    logic              flush = 1'b0, freeze = 1'b0;
    logic              stall_if, ex_valid;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0]   ex_r_data1, ex_r_data2, ex_imm, ex_pc;
    ctrl_t             ex_ctrl;

    int tests = 0;
    int fails = 0;

    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_r_data1(id_r_data1), .id_r_data2(id_r_data2),
        .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl),
        .flush(flush), .freeze(freeze), .stall_if(stall_if),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_r_data1(ex_r_data1), .ex_r_data2(ex_r_data2), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_ctrl(ex_ctrl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the EX slot should contain, as a plain record.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic [XLEN-1:0]   d1, d2, imm, pc;
        ctrl_t             ctrl;
    } ex_m_t;

    ex_m_t m = '0;

    function automatic logic model_lu(input ex_m_t s);
        logic reads;
        reads = (id_use_rs1 && id_rs1 == s.rd) || (id_use_rs2 && id_rs2 == s.rd);
        return s.valid && s.ctrl.mem_read && s.rd != 0 && id_valid && reads;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m = '0;
        else if (freeze) m = m;
        else if (flush || model_lu(m)) m = '0;
        else begin
            m.valid = id_valid;
            m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
            m.d1 = id_r_data1; m.d2 = id_r_data2; m.imm = id_imm; m.pc = id_pc;
            m.ctrl = id_valid ? id_ctrl : '0;
        end
    end

    always @(negedge clk) begin
        chk("ex_valid", 64'(ex_valid), 64'(m.valid));
        chk("ex_rs1", 64'(ex_rs1), 64'(m.rs1));
        chk("ex_rs2", 64'(ex_rs2), 64'(m.rs2));
        chk("ex_rd", 64'(ex_rd), 64'(m.rd));
        chk("ex_r_data1", 64'(ex_r_data1), 64'(m.d1));
        chk("ex_r_data2", 64'(ex_r_data2), 64'(m.d2));
        chk("ex_imm", 64'(ex_imm), 64'(m.imm));
        chk("ex_pc", 64'(ex_pc), 64'(m.pc));
        chk("ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
        chk("stall_if", 64'(stall_if), 64'(freeze || (model_lu(m) && !flush)));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input int rs1, input logic u1, input int rs2,
                          input logic u2, input int rd, input logic load);
        ctrl_t c;
        c = '0;
        c.reg_write = 1'b1;
        c.mem_read = load;
        c.mem_to_reg = load;
        c.alu_src = load;
        c.alu_op = 4'(ALU_ADD);
        id_valid = v;
        id_rs1 = REG_AW'(rs1); id_use_rs1 = u1;
        id_rs2 = REG_AW'(rs2); id_use_rs2 = u2;
        id_rd = REG_AW'(rd);
        id_r_data1 = XLEN'(rs1 * 10); id_r_data2 = XLEN'(rs2 * 10);
        id_imm = XLEN'(rd); id_pc = id_pc + 4;
        id_ctrl = c;
    endtask

    initial begin
        // Async reset mid-cycle, before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("reset_ex_valid", 64'(ex_valid), 64'd0);
        chk("reset_ex_ctrl", 64'(ex_ctrl), 64'd0);
        chk("reset_ex_pc", 64'(ex_pc), 64'd0);
        chk("reset_stall_if", 64'(stall_if), 64'd0);
        tick;
        reset = 1'b0;

        // Straight pass-through
        set_id(1, 2, 1, 0, 0, 5, 0);
        id_r_data1 = 32'd250;
        tick;
        chk("pass_ex_rs1", 64'(ex_rs1), 64'd2);
        chk("pass_ex_r_data1", 64'(ex_r_data1), 64'd250);
        chk("pass_ex_rd", 64'(ex_rd), 64'd5);
        chk("pass_ex_valid", 64'(ex_valid), 64'd1);

        // Load-use: lw x3 then add reading x3 via rs2
        set_id(1, 0, 0, 0, 0, 3, 1);
        tick;
        set_id(1, 1, 1, 3, 1, 4, 0);
        #1 chk("lu_stall", 64'(stall_if), 64'd1);
        tick;
        chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
        chk("lu_bubble_ctrl", 64'(ex_ctrl), 64'd0);
        chk("lu_stall_clear", 64'(stall_if), 64'd0);
        tick;
        chk("lu_replay_valid", 64'(ex_valid), 64'd1);
        chk("lu_replay_rd", 64'(ex_rd), 64'd4);

        // Load to x0 never hazards; unused rs1 matching rd never hazards
        set_id(1, 0, 0, 0, 0, 0, 1);
        tick;
        set_id(1, 0, 1, 0, 1, 2, 0);
        #1 chk("x0_no_stall", 64'(stall_if), 64'd0);
        set_id(1, 0, 0, 0, 0, 6, 1);
        tick;
        set_id(1, 6, 0, 1, 1, 7, 0);
        #1 chk("unused_no_stall", 64'(stall_if), 64'd0);
        tick;
        chk("unused_no_bubble", 64'(ex_valid), 64'd1);
        chk("unused_rd", 64'(ex_rd), 64'd7);

        // Flush coinciding with load-use: bubble, no stall
        set_id(1, 0, 0, 0, 0, 7, 1);
        tick;
        set_id(1, 7, 1, 0, 0, 9, 0);
        flush = 1'b1;
        #1 chk("flush_lu_stall", 64'(stall_if), 64'd0);
        tick;
        flush = 1'b0;
        chk("flush_bubble", 64'(ex_valid), 64'd0);
        set_id(0, 0, 0, 0, 0, 0, 0);
        tick;

        // Freeze held for three cycles over a pending load-use
        set_id(1, 0, 0, 0, 0, 8, 1);
        tick;
        set_id(1, 0, 0, 8, 1, 9, 0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("frz_ex_rd", 64'(ex_rd), 64'd8);
            chk("frz_ex_valid", 64'(ex_valid), 64'd1);
            chk("frz_stall", 64'(stall_if), 64'd1);
        end
        freeze = 1'b0;
        #1 chk("frz_release_stall", 64'(stall_if), 64'd1);
        tick;
        chk("frz_bubble", 64'(ex_valid), 64'd0);
        tick;
        chk("frz_replay_rd", 64'(ex_rd), 64'd9);
        chk("frz_replay_valid", 64'(ex_valid), 64'd1);

        // Reset asserted while a load-use stall is pending
        set_id(1, 0, 0, 0, 0, 3, 1);
        tick;
        set_id(1, 3, 1, 0, 0, 4, 0);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(ex_valid), 64'd0);
        chk("rst_mid_stall", 64'(stall_if), 64'd0);
        #1 reset = 1'b0;
        tick;

        // Randomized traffic, small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            ctrl_t c;
            c = ctrl_t'($urandom_range(0, 1023));
            c.mem_read = ($urandom_range(0, 99) < 45);
            id_valid = ($urandom_range(0, 9) != 0);
            id_rs1 = REG_AW'($urandom_range(0, 3));
            id_rs2 = REG_AW'($urandom_range(0, 3));
            id_rd = REG_AW'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom);
            id_use_rs2 = 1'($urandom);
            id_r_data1 = $urandom; id_r_data2 = $urandom;
            id_imm = $urandom; id_pc = $urandom;
            id_ctrl = c;
            flush = ($urandom_range(0, 9) == 0);
            freeze = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 499) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick;
        end
        flush = 1'b0;
        freeze = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
